// File: rtl/pc_stack_if.sv
// pc_stack_if: control-unit side of the program counter / return stack.
interface pc_stack_if #(
  parameter int ADDRRAM_WIDTH = 10,
  parameter int STACK_DEPTH   = 8
);
  logic                               ena_i;
  logic [2:0]                         op_i;
  logic [ADDRRAM_WIDTH-1:0]           target_i;
  logic                               clear_err_i;
  logic [ADDRRAM_WIDTH-1:0]           pc_o;
  logic [ADDRRAM_WIDTH-1:0]           tos_o;
  logic [$clog2(STACK_DEPTH+1)-1:0]   depth_o;
  logic                               full_o;
  logic                               empty_o;
  logic                               overflow_o;
  logic                               underflow_o;
  modport master (output ena_i, op_i, target_i, clear_err_i,
                  input  pc_o, tos_o, depth_o, full_o, empty_o, overflow_o, underflow_o);
  modport slave  (input  ena_i, op_i, target_i, clear_err_i,
                  output pc_o, tos_o, depth_o, full_o, empty_o, overflow_o, underflow_o);
endinterface

// File: rtl/pc_stack.sv
// pc_stack: program counter with increment, jump, branch and a LIFO return-address stack.
module pc_stack #(
  parameter int ADDRRAM_WIDTH = 10,
  parameter int STACK_DEPTH   = 8,
  parameter int RESET_ADDR    = 0,
  parameter int INC_STEP      = 1
) (
  input logic       clock_i,
  input logic       nreset_i,
  pc_stack_if.slave bus
);
  localparam int W  = ADDRRAM_WIDTH;
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int PW = $clog2(STACK_DEPTH);
  typedef enum logic [2:0] {HOLD, INC, JUMP, BRANCH, CALL, RET, RST, RSV} op_t;
  logic [W-1:0]  pc_q, pc_d, ret_addr, tos;
  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d, udf_q, udf_d, full, empty, push, call, ret;
  logic [W-1:0]  stack_q [STACK_DEPTH];
  assign full     = depth_q == DW'(STACK_DEPTH);
  assign empty    = depth_q == '0;
  assign tos      = empty ? '0 : stack_q[PW'(depth_q - 1'b1)];
  assign ret_addr = pc_q + W'(INC_STEP);
  assign call     = bus.ena_i && bus.op_i == CALL;
  assign ret      = bus.ena_i && bus.op_i == RET;
  assign push     = call && !full;
  // a flagged error always wins over a simultaneous clear
  assign ovf_d    = (call && full) || (ovf_q && !bus.clear_err_i);
  assign udf_d    = (ret && empty) || (udf_q && !bus.clear_err_i);
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    if (bus.ena_i)
      case (op_t'(bus.op_i))
        INC:     pc_d = ret_addr;
        JUMP:    pc_d = bus.target_i;
        BRANCH:  pc_d = pc_q + bus.target_i;
        CALL:    if (!full) begin
                   pc_d    = bus.target_i;
                   depth_d = depth_q + 1'b1;
                 end
        RET:     if (!empty) begin
                   pc_d    = tos;
                   depth_d = depth_q - 1'b1;
                 end
        RST:     begin
                   pc_d    = W'(RESET_ADDR);
                   depth_d = '0;
                 end
        default: ;
      endcase
  end
  always_ff @(posedge clock_i or negedge nreset_i)
    if (!nreset_i) begin
      pc_q    <= W'(RESET_ADDR);
      depth_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  always_ff @(posedge clock_i)
    if (push) stack_q[PW'(depth_q)] <= ret_addr;
  assign bus.pc_o        = pc_q;
  assign bus.tos_o       = tos;
  assign bus.depth_o     = depth_q;
  assign bus.full_o      = full;
  assign bus.empty_o     = empty;
  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = udf_q;
endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed vectors with a queue scoreboard checked on the falling edge.
module tb_pc_stack;
  localparam int W = 10;
  localparam int D = 4;
  typedef struct {
    logic [W-1:0] pc;
    logic [W-1:0] tos;
    logic [2:0]   depth;
    logic         ovf;
    logic         udf;
    string        name;
  } exp_t;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  pc_stack_if #(.ADDRRAM_WIDTH(W), .STACK_DEPTH(D)) bus ();
  pc_stack #(.ADDRRAM_WIDTH(W), .STACK_DEPTH(D), .RESET_ADDR(0), .INC_STEP(1)) dut (
    .clock_i (clk),
    .nreset_i(nreset),
    .bus     (bus)
  );
  always #5 clk = ~clk;

  task automatic expect_now(input logic [W-1:0] pc, tos, input logic [2:0] d,
                            input logic o, u, input string nm);
    exp_t e;
    e.pc = pc; e.tos = tos; e.depth = d; e.ovf = o; e.udf = u; e.name = nm;
    q.push_back(e);
  endtask

  task automatic step(input logic en, input logic [2:0] op, input logic [W-1:0] t, input logic clr,
                      input logic [W-1:0] pc, tos, input logic [2:0] d, input logic o, u,
                      input string nm);
    @(negedge clk);
    bus.ena_i = en; bus.op_i = op; bus.target_i = t; bus.clear_err_i = clr;
    @(posedge clk);
    expect_now(pc, tos, d, o, u, nm);
  endtask

  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e;
      logic full_e, empty_e;
      e = q.pop_front();
      full_e  = e.depth == 3'(D);
      empty_e = e.depth == 3'd0;
      tests++;
      if (bus.pc_o !== e.pc || bus.tos_o !== e.tos || bus.depth_o !== e.depth ||
          bus.full_o !== full_e || bus.empty_o !== empty_e ||
          bus.overflow_o !== e.ovf || bus.underflow_o !== e.udf) begin
        fails++;
        $display("FAIL %s: got pc=%h tos=%h depth=%0d full=%b empty=%b ovf=%b udf=%b, want pc=%h tos=%h depth=%0d full=%b empty=%b ovf=%b udf=%b",
                 e.name, bus.pc_o, bus.tos_o, bus.depth_o, bus.full_o, bus.empty_o,
                 bus.overflow_o, bus.underflow_o, e.pc, e.tos, e.depth, full_e, empty_e, e.ovf, e.udf);
      end
    end

  initial begin
    bus.ena_i = 1'b0; bus.op_i = 3'd0; bus.target_i = '0; bus.clear_err_i = 1'b0;
    repeat (2) @(posedge clk);
    expect_now(0, 0, 0, 0, 0, "reset");
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 1; i <= 5; i++) step(1, 3'd1, 0, 0, 10'(i), 0, 0, 0, 0, "inc");
    step(0, 3'd1, 0, 0, 5, 0, 0, 0, 0, "ena0_a");
    step(0, 3'd1, 0, 0, 5, 0, 0, 0, 0, "ena0_b");
    step(1, 3'd2, 10'd1020, 0, 1020, 0, 0, 0, 0, "jump1020");
    step(1, 3'd1, 0, 0, 1021, 0, 0, 0, 0, "inc1021");
    step(1, 3'd1, 0, 0, 1022, 0, 0, 0, 0, "inc1022");
    step(1, 3'd1, 0, 0, 1023, 0, 0, 0, 0, "inc1023");
    step(1, 3'd1, 0, 0, 0, 0, 0, 0, 0, "inc_wrap");
    step(1, 3'd1, 0, 0, 1, 0, 0, 0, 0, "inc1");
    step(1, 3'd3, 10'h3FE, 0, 1023, 0, 0, 0, 0, "branch_neg");
    step(1, 3'd2, 10'h100, 0, 10'h100, 0, 0, 0, 0, "jump100");
    step(1, 3'd4, 10'h200, 0, 10'h200, 10'h101, 1, 0, 0, "call200");
    step(1, 3'd4, 10'h300, 0, 10'h300, 10'h201, 2, 0, 0, "call300");
    step(1, 3'd5, 0, 0, 10'h201, 10'h101, 1, 0, 0, "ret1");
    step(1, 3'd5, 0, 0, 10'h101, 0, 0, 0, 0, "ret2");
    step(1, 3'd4, 10'h10, 0, 10'h10, 10'h102, 1, 0, 0, "fill1");
    step(1, 3'd4, 10'h20, 0, 10'h20, 10'h11, 2, 0, 0, "fill2");
    step(1, 3'd4, 10'h30, 0, 10'h30, 10'h21, 3, 0, 0, "fill3");
    step(1, 3'd4, 10'h40, 0, 10'h40, 10'h31, 4, 0, 0, "fill4");
    step(1, 3'd4, 10'h50, 0, 10'h40, 10'h31, 4, 1, 0, "call_full");
    step(1, 3'd4, 10'h60, 1, 10'h40, 10'h31, 4, 1, 0, "clr_vs_ovf");
    step(0, 3'd4, 10'h60, 1, 10'h40, 10'h31, 4, 0, 0, "clr_alone");
    step(1, 3'd5, 0, 0, 10'h31, 10'h21, 3, 0, 0, "ret_full");
    step(1, 3'd4, 10'h70, 0, 10'h70, 10'h32, 4, 0, 0, "refill");
    step(1, 3'd4, 10'h80, 0, 10'h70, 10'h32, 4, 1, 0, "ovf_again");
    step(1, 3'd5, 0, 0, 10'h32, 10'h21, 3, 1, 0, "ret_d3");
    step(1, 3'd6, 0, 0, 0, 0, 0, 1, 0, "rst_op");
    step(1, 3'd5, 0, 0, 0, 0, 0, 1, 1, "ret_empty");
    step(1, 3'd0, 0, 1, 0, 0, 0, 0, 0, "clr_both");
    step(1, 3'd7, 10'h55, 0, 0, 0, 0, 0, 0, "reserved");
    step(1, 3'd2, 10'h40, 0, 10'h40, 0, 0, 0, 0, "jump40");
    step(1, 3'd4, 10'h50, 0, 10'h50, 10'h41, 1, 0, 0, "call50");
    step(1, 3'd4, 10'h60, 0, 10'h60, 10'h51, 2, 0, 0, "call60");
    @(negedge clk);
    bus.ena_i = 1'b0;
    @(posedge clk);
    #3 nreset = 1'b0;
    expect_now(0, 0, 0, 0, 0, "async_reset");
    @(negedge clk);
    nreset = 1'b1;
    step(1, 3'd5, 0, 0, 0, 0, 0, 0, 1, "ret_after_reset");
    @(negedge clk);
    bus.ena_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter with a hardware return-address stack, the successor of the plain loadable PC register. The same clock-enabled, asynchronously reset address register, plus in-block increment, absolute jump, PC-relative branch, call/return via a LIFO of configurable depth, and sticky stack-error flags. It sits between the control unit (which issues `op_i`) and the instruction RAM address bus (`pc_o`).

## Interface
- `ADDRRAM_WIDTH`, 10: width of the program address and of every stack entry.
- `STACK_DEPTH`, 8: number of return-address entries; must be ≥ 2.
- `RESET_ADDR`, 0: value loaded into the PC on reset and by op RST.
- `INC_STEP`, 1: increment applied by INC and used for the CALL return address.
- `clock_i`  in  1  system clock; all state changes on the rising edge.
- `nreset_i`  in  1  reset, asynchronous, active-low.
- `ena_i`  in  1  advance enable; when 0 no state changes except `clear_err_i`.
- `op_i`  in  3  operation select, sampled when `ena_i`=1.
- `target_i`  in  ADDRRAM_WIDTH  jump/call target (absolute) or branch offset (two's complement).
- `clear_err_i`  in  1  clears the sticky error flags; independent of `ena_i`.
- `pc_o`  out  ADDRRAM_WIDTH  current program address (registered).
- `tos_o`  out  ADDRRAM_WIDTH  current top-of-stack entry; 0 when the stack is empty.
- `depth_o`  out  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- `full_o`  out  1  `depth_o` == STACK_DEPTH.
- `empty_o`  out  1  `depth_o` == 0.
- `overflow_o`  out  1  sticky: a CALL was attempted while full.
- `underflow_o`  out  1  sticky: a RET was attempted while empty.

## Operation
- Reset (`nreset_i`=0, asynchronous, immediate): `pc_o`=RESET_ADDR, `depth_o`=0, `overflow_o`=`underflow_o`=0, `tos_o`=0, `empty_o`=1, `full_o`=0. Stack RAM contents are not reset and are never observable while invalid.
- Op codes (effective only with `ena_i`=1):
  - 000 HOLD: no change.
  - 001 INC: pc ← pc + INC_STEP.
  - 010 JUMP: pc ← `target_i`.
  - 011 BRANCH: pc ← pc + sign-extended `target_i`.
  - 100 CALL: push (pc + INC_STEP), pc ← `target_i`, depth+1.
  - 101 RET: pc ← top entry, pop, depth−1.
  - 110 RST: pc ← RESET_ADDR, depth ← 0 (stack flushed); flags unchanged.
  - 111 reserved: treated as HOLD.
- All PC arithmetic is modulo 2^ADDRRAM_WIDTH; carry and overflow are discarded silently (wrap from max to 0 is legal, not an error).
- CALL while full: entire op suppressed (pc and stack unchanged), `overflow_o` set.
- RET while empty: entire op suppressed (pc unchanged), `underflow_o` set.
- `clear_err_i`=1 clears both flags on the next edge; if an error event occurs in the same cycle, the flag is set (set wins).
- Stack is a true LIFO: `tos_o` always shows the most recently pushed, unpopped entry.

## Timing
- Fully registered; every op takes effect on the rising edge where sampled, visible on `pc_o`/`depth_o`/`tos_o` in the same cycle after that edge (latency 1).
- `full_o`, `empty_o` and `tos_o` are derived from registered state only; no combinational path from any input to any output.
- Back-to-back CALL/RET on consecutive cycles are supported at full rate; CALL immediately followed by RET returns to the CALL address + INC_STEP.
- `ena_i`=0 freezes pc, stack and depth indefinitely; the op presented is discarded, not queued.
- Reset asserted mid-sequence aborts immediately; the first enabled op after release operates from RESET_ADDR with an empty stack.

## Test plan
- Reset then 5 cycles INC (W=10, step 1) -> `pc_o` 0,1,2,3,4,5; hold `ena_i`=0 two cycles -> stays 5.
- pc=1020, INC ×5 -> 1021,1022,1023,0,1; BRANCH `target_i`=0x3FE (−2) from 1 -> 1023.
- JUMP 0x100, CALL 0x200, CALL 0x300, RET, RET -> pc 0x100,0x200,0x300,0x201,0x101; depth 0,1,2,1,0; `tos_o` 0x101 then 0x201 then 0x101.
- STACK_DEPTH=4: five CALLs -> depth 4, `full_o`=1, fifth CALL leaves pc at 4th target, `overflow_o`=1; `clear_err_i` with concurrent CALL -> flag stays 1; `clear_err_i` alone -> 0.
- From reset, RET -> pc stays 0, `underflow_o`=1, `empty_o`=1; RST with depth 3 -> pc=RESET_ADDR, depth 0, flags unchanged.
- Assert `nreset_i` low asynchronously between edges with depth 2 -> outputs return to reset values before next edge; after release, RET -> underflow.
